// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with memory handshake, bus-timeout and illegal-opcode traps.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_i,
   input  logic [6:0]       ir_opcode_i,
   input  logic             branch_taken_i,
   input  logic             mem_ready_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             mem_addr_sel_o,
   output logic             ir_we_o,
   output logic             pc_we_o,
   output logic [1:0]       pc_src_o,
   output logic             alu_a_sel_o,
   output logic             alu_b_sel_o,
   output logic [1:0]       alu_op_o,
   output logic             rf_we_o,
   output logic [1:0]       wb_sel_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [CNT_W-1:0] instret_o
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
   logic [1:0]         trap_cause_q, trap_cause_d;
   logic [CNT_W-1:0]   instret_q, instret_d;
   logic               retire_c;
   logic               legal_c;
   logic               alu_a_c, alu_b_c;
   logic [1:0]         alu_op_c;
   logic               timeout_c;

   assign wait_inc  = wait_q + WAIT_W'(1);
   assign timeout_c = (wait_inc == WAIT_W'(MEM_TIMEOUT));

   // ALU operand/op selects implied by the latched opcode
   always_comb begin
      legal_c  = 1'b1;
      alu_a_c  = 1'b0;
      alu_b_c  = 1'b0;
      alu_op_c = 2'd0;
      case (ir_opcode_i)
         OP_R:                begin alu_op_c = 2'd1; end
         OP_OPIMM:            begin alu_b_c = 1'b1; alu_op_c = 2'd1; end
         OP_LOAD, OP_STORE:   begin alu_b_c = 1'b1; end
         OP_AUIPC:            begin alu_a_c = 1'b1; alu_b_c = 1'b1; end
         OP_JALR:             begin alu_b_c = 1'b1; end
         OP_BRANCH:           begin alu_op_c = 2'd2; end
         OP_JAL, OP_LUI:      begin end
         default:             begin legal_c = 1'b0; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wait_q       <= '0;
         trap_cause_q <= 2'd0;
         instret_q    <= '0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         trap_cause_q <= trap_cause_d;
         instret_q    <= instret_d;
      end
   end

   // Next state and datapath controls
   always_comb begin
      state_d        = state_q;
      wait_d         = '0;
      trap_cause_d   = trap_cause_q;
      retire_c       = 1'b0;
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_sel_o = 1'b0;
      ir_we_o        = 1'b0;
      pc_we_o        = 1'b0;
      pc_src_o       = 2'd0;
      alu_a_sel_o    = 1'b0;
      alu_b_sel_o    = 1'b0;
      alu_op_o       = 2'd0;
      rf_we_o        = 1'b0;
      wb_sel_o       = 2'd0;
      trap_o         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run_i) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req_o = 1'b1;
            if (mem_ready_i) begin
               ir_we_o = 1'b1;
               state_d = S_DECODE;
            end else if (timeout_c) begin
               state_d      = S_TRAP;
               trap_cause_d = 2'd2;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_DECODE: begin
            if (legal_c) begin
               state_d = S_EXEC;
            end else begin
               state_d      = S_TRAP;
               trap_cause_d = 2'd1;
            end
         end
         S_EXEC: begin
            alu_a_sel_o = alu_a_c;
            alu_b_sel_o = alu_b_c;
            alu_op_o    = alu_op_c;
            if (ir_opcode_i == OP_BRANCH) begin
               pc_we_o  = 1'b1;
               pc_src_o = branch_taken_i ? 2'd1 : 2'd0;
               retire_c = 1'b1;
            end else if (ir_opcode_i == OP_LOAD || ir_opcode_i == OP_STORE) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req_o      = 1'b1;
            mem_addr_sel_o = 1'b1;
            mem_we_o       = (ir_opcode_i == OP_STORE);
            alu_a_sel_o    = alu_a_c;
            alu_b_sel_o    = alu_b_c;
            alu_op_o       = alu_op_c;
            if (mem_ready_i) begin
               if (ir_opcode_i == OP_STORE) begin
                  pc_we_o  = 1'b1;
                  retire_c = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout_c) begin
               state_d      = S_TRAP;
               trap_cause_d = 2'd2;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_WB: begin
            rf_we_o  = 1'b1;
            pc_we_o  = 1'b1;
            retire_c = 1'b1;
            case (ir_opcode_i)
               OP_LOAD:          wb_sel_o = 2'd1;
               OP_JAL, OP_JALR:  wb_sel_o = 2'd2;
               OP_LUI:           wb_sel_o = 2'd3;
               default:          wb_sel_o = 2'd0;
            endcase
            if (ir_opcode_i == OP_JAL) pc_src_o = 2'd1;
            if (ir_opcode_i == OP_JALR) begin
               pc_src_o    = 2'd2;
               alu_a_sel_o = alu_a_c;
               alu_b_sel_o = alu_b_c;
               alu_op_o    = alu_op_c;
            end
         end
         S_TRAP: begin
            trap_o = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // run is only honoured at instruction boundaries
      if (retire_c) state_d = run_i ? S_FETCH : S_IDLE;
      instret_d = retire_c ? instret_q + CNT_W'(1) : instret_q;
   end

   assign trap_cause_o = trap_cause_q;
   assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction transaction model (latency,
// strobe counts, selects, traps, instret) driven by a memory responder with random waits.
module tb_multicycle_ctrl;

   localparam int unsigned MT = 4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run_i = 1'b0;
   logic [6:0]  ir_opcode_i = 7'd0;
   logic        branch_taken_i = 1'b0;
   logic        mem_ready_i = 1'b0;
   logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o;
   logic [1:0]  pc_src_o, alu_op_o, wb_sel_o, trap_cause_o;
   logic        alu_a_sel_o, alu_b_sel_o, rf_we_o, trap_o;
   logic [31:0] instret_o;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] exp_instret = 32'd0;
   logic [6:0]  legal_ops [9];

   multicycle_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .run_i(run_i), .ir_opcode_i(ir_opcode_i),
      .branch_taken_i(branch_taken_i), .mem_ready_i(mem_ready_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o),
      .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
      .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .alu_op_o(alu_op_o),
      .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o), .trap_o(trap_o),
      .trap_cause_o(trap_cause_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   // Reference tables: {alu_a, alu_b, alu_op} used by the instruction
   function automatic logic [3:0] ref_alu(input logic [6:0] op);
      case (op)
         OP_R:              return 4'b0001;
         OP_OPIMM:          return 4'b0101;
         OP_LOAD, OP_STORE: return 4'b0100;
         OP_AUIPC:          return 4'b1100;
         OP_JALR:           return 4'b0100;
         OP_BRANCH:         return 4'b0010;
         default:           return 4'b0000;
      endcase
   endfunction

   function automatic int ref_base(input logic [6:0] op);
      if (op == OP_BRANCH) return 3;
      if (op == OP_LOAD) return 5;
      return 4;
   endfunction

   function automatic logic [1:0] ref_wb(input logic [6:0] op);
      if (op == OP_LOAD) return 2'd1;
      if (op == OP_JAL || op == OP_JALR) return 2'd2;
      if (op == OP_LUI) return 2'd3;
      return 2'd0;
   endfunction

   function automatic logic [1:0] ref_pc_src(input logic [6:0] op, input logic taken);
      if (op == OP_BRANCH) return taken ? 2'd1 : 2'd0;
      if (op == OP_JAL) return 2'd1;
      if (op == OP_JALR) return 2'd2;
      return 2'd0;
   endfunction

   function automatic bit ref_legal(input logic [6:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Runs one instruction from IDLE/FETCH through retire or trap; fw/mw are wait cycles
   task automatic exec_instr(input logic [6:0] op, input int fw, input int mw,
                             input logic taken, input bit drop_run, input string name);
      int cyc = 0, fetch_req = 0, msel = 0, mwe = 0, rfw = 0, pcw = 0, waits = 0, tgt;
      int exp_cyc, exp_rf, exp_msel, exp_mwe;
      logic [1:0] obs_wb = 2'd0, obs_pc_src = 2'd0, exp_cause;
      logic [3:0] obs_alu = 4'd0, obs_mem_alu = 4'd0;
      bit started = 0, done = 0, trapped = 0, load_ir, ls;
      ls = (op == OP_LOAD || op == OP_STORE);
      exp_cause = 2'd0;
      if (fw >= int'(MT)) begin exp_cyc = MT + 1; exp_cause = 2'd2; end
      else if (!ref_legal(op)) begin exp_cyc = fw + 3; exp_cause = 2'd1; end
      else if (ls && mw >= int'(MT)) begin exp_cyc = fw + MT + 4; exp_cause = 2'd2; end
      else exp_cyc = ref_base(op) + fw + (ls ? mw : 0);
      exp_rf   = (op == OP_BRANCH || op == OP_STORE) ? 0 : 1;
      exp_msel = ls ? mw + 1 : 0;
      exp_mwe  = (op == OP_STORE) ? mw + 1 : 0;
      run_i = 1'b1;
      for (int k = 0; k < 64 && !done; k++) begin
         mem_ready_i = 1'b0;
         branch_taken_i = taken;
         #1;
         if (mem_req_o) begin
            tgt = mem_addr_sel_o ? mw : fw;
            if (waits == tgt) mem_ready_i = 1'b1;
         end
         #1;
         if (mem_req_o && !mem_addr_sel_o) begin started = 1; fetch_req++; end
         if (started) cyc++;
         if (started && drop_run) run_i = 1'b0;
         if (mem_req_o && mem_addr_sel_o) begin msel++; obs_mem_alu = {alu_a_sel_o, alu_b_sel_o, alu_op_o}; end
         if (mem_we_o) mwe++;
         if (rf_we_o) begin rfw++; obs_wb = wb_sel_o; end
         if (pc_we_o) begin
            pcw++; obs_pc_src = pc_src_o; obs_alu = {alu_a_sel_o, alu_b_sel_o, alu_op_o}; done = 1;
         end
         if (trap_o) begin trapped = 1; done = 1; end
         if (mem_req_o) waits = mem_ready_i ? 0 : waits + 1;
         load_ir = ir_we_o;
         @(posedge clk); #1;
         if (load_ir) ir_opcode_i = op;
      end
      mem_ready_i = 1'b0;
      n_checks++;
      if (!done) begin
         $display("FAIL %s timeout: no retire or trap within 64 cycles", name);
         return;
      end else n_pass++;
      n_checks++;
      if (cyc !== exp_cyc) $display("FAIL %s cycles: got %0d expected %0d", name, cyc, exp_cyc);
      else n_pass++;
      n_checks++;
      if (instret_o !== exp_instret + ((exp_cause == 2'd0) ? 32'd1 : 32'd0))
         $display("FAIL %s instret: got %0d expected %0d", name, instret_o,
                  exp_instret + ((exp_cause == 2'd0) ? 32'd1 : 32'd0));
      else n_pass++;
      if (exp_cause == 2'd0) exp_instret = exp_instret + 32'd1;
      n_checks++;
      if ({trap_o, trap_cause_o} !== {(exp_cause != 2'd0), exp_cause})
         $display("FAIL %s trap: got trap=%0b cause=%0d expected cause=%0d", name, trap_o, trap_cause_o, exp_cause);
      else n_pass++;
      if (trapped || exp_cause != 2'd0) return;
      n_checks++;
      if (rfw !== exp_rf) $display("FAIL %s rf_we count: got %0d expected %0d", name, rfw, exp_rf);
      else n_pass++;
      if (exp_rf == 1) begin
         n_checks++;
         if (obs_wb !== ref_wb(op)) $display("FAIL %s wb_sel: got %0d expected %0d", name, obs_wb, ref_wb(op));
         else n_pass++;
      end
      n_checks++;
      if (pcw !== 1 || obs_pc_src !== ref_pc_src(op, taken))
         $display("FAIL %s pc_we/pc_src: got %0d/%0d expected 1/%0d", name, pcw, obs_pc_src, ref_pc_src(op, taken));
      else n_pass++;
      n_checks++;
      if (fetch_req !== fw + 1 || msel !== exp_msel || mwe !== exp_mwe)
         $display("FAIL %s mem cycles: got fetch=%0d mem=%0d we=%0d expected %0d/%0d/%0d",
                  name, fetch_req, msel, mwe, fw + 1, exp_msel, exp_mwe);
      else n_pass++;
      if (ls) begin
         n_checks++;
         if (obs_mem_alu !== ref_alu(op)) $display("FAIL %s mem alu sel: got %h expected %h", name, obs_mem_alu, ref_alu(op));
         else n_pass++;
      end
      if (op == OP_BRANCH || op == OP_JALR) begin
         n_checks++;
         if (obs_alu !== ref_alu(op)) $display("FAIL %s alu sel at retire: got %h expected %h", name, obs_alu, ref_alu(op));
         else n_pass++;
      end
   endtask

   task automatic do_reset(input string name);
      @(negedge clk);
      rst_n = 1'b0; run_i = 1'b0; mem_ready_i = 1'b0;
      #1;
      n_checks++;
      if ({mem_req_o, mem_we_o, mem_addr_sel_o, ir_we_o, pc_we_o, pc_src_o, alu_a_sel_o, alu_b_sel_o,
           alu_op_o, rf_we_o, wb_sel_o, trap_o, trap_cause_o, instret_o} !== '0)
         $display("FAIL %s reset outputs: got req=%0b trap=%0b cause=%0d instret=%0d expected all zero",
                  name, mem_req_o, trap_o, trap_cause_o, instret_o);
      else n_pass++;
      exp_instret = 32'd0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset("reset");
   endtask

   task automatic test_add();
      exec_instr(OP_R, 0, 0, 1'b0, 1'b0, "add");
   endtask

   task automatic test_load_wait();
      exec_instr(OP_LOAD, 0, 3, 1'b0, 1'b0, "load_wait3");
   endtask

   task automatic test_branch();
      exec_instr(OP_BRANCH, 0, 0, 1'b1, 1'b0, "branch_taken");
      exec_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0, "branch_not_taken");
   endtask

   task automatic test_run_stop();
      exec_instr(OP_OPIMM, 1, 0, 1'b0, 1'b1, "opimm_run_drop");
      for (int k = 0; k < 4; k++) begin
         #2;
         n_checks++;
         if (mem_req_o !== 1'b0 || instret_o !== exp_instret)
            $display("FAIL idle_after_stop: got req=%0b instret=%0d expected 0/%0d", mem_req_o, instret_o, exp_instret);
         else n_pass++;
         @(posedge clk); #1;
      end
      exec_instr(OP_AUIPC, 0, 0, 1'b0, 1'b0, "auipc_resume");
   endtask

   task automatic test_back_to_back();
      logic [6:0] op;
      for (int i = 0; i < 40; i++) begin
         op = legal_ops[$urandom_range(0, 8)];
         exec_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d_op%b", i, op));
      end
   endtask

   task automatic test_reset_mid_store();
      bit hit = 0, load_ir;
      run_i = 1'b1;
      for (int k = 0; k < 40 && !hit; k++) begin
         mem_ready_i = 1'b0;
         #1;
         if (mem_req_o && !mem_addr_sel_o) mem_ready_i = 1'b1;
         #1;
         if (mem_we_o) begin
            hit = 1;
            rst_n = 1'b0;
            #1;
            n_checks++;
            if ({mem_req_o, mem_we_o, trap_o} !== 3'b000 || instret_o !== 32'd0)
               $display("FAIL reset_mid_store: got req=%0b we=%0b instret=%0d expected 0/0/0",
                        mem_req_o, mem_we_o, instret_o);
            else n_pass++;
         end else begin
            load_ir = ir_we_o;
            @(posedge clk); #1;
            if (load_ir) ir_opcode_i = OP_STORE;
         end
      end
      n_checks++;
      if (!hit) $display("FAIL reset_mid_store timeout: store never reached MEM");
      else n_pass++;
      mem_ready_i = 1'b0;
      exp_instret = 32'd0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      exec_instr(OP_LUI, 0, 0, 1'b0, 1'b0, "lui_after_reset");
   endtask

   task automatic test_trap_hold();
      exec_instr(7'b0000000, 0, 0, 1'b0, 1'b0, "illegal");
      run_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #2;
         n_checks++;
         if ({trap_o, trap_cause_o, mem_req_o, ir_we_o, pc_we_o, rf_we_o} !== 7'b1010000 || instret_o !== exp_instret)
            $display("FAIL trap_hold cycle %0d: got trap=%0b cause=%0d req=%0b instret=%0d expected 1/1/0/%0d",
                     k, trap_o, trap_cause_o, mem_req_o, instret_o, exp_instret);
         else n_pass++;
         @(posedge clk); #1;
      end
      do_reset("reset_after_illegal");
   endtask

   task automatic test_timeout();
      exec_instr(OP_R, int'(MT), 0, 1'b0, 1'b0, "fetch_timeout");
      do_reset("reset_after_fetch_timeout");
      exec_instr(OP_JAL, int'(MT) - 1, 0, 1'b0, 1'b0, "fetch_ready_last_cycle");
      exec_instr(OP_STORE, 0, int'(MT) - 1, 1'b0, 1'b0, "store_ready_last_cycle");
      exec_instr(OP_STORE, 0, int'(MT), 1'b0, 1'b0, "store_mem_timeout");
      do_reset("reset_after_mem_timeout");
   endtask

   initial begin
      legal_ops[0] = OP_R;      legal_ops[1] = OP_OPIMM; legal_ops[2] = OP_LOAD;
      legal_ops[3] = OP_STORE;  legal_ops[4] = OP_BRANCH; legal_ops[5] = OP_JAL;
      legal_ops[6] = OP_JALR;   legal_ops[7] = OP_LUI;   legal_ops[8] = OP_AUIPC;
      test_reset();
      test_add();
      test_load_wait();
      test_branch();
      test_run_stop();
      test_back_to_back();
      test_reset_mid_store();
      test_trap_hold();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared datapath (register file, ALU, immediate generator, PC, single memory port).
- Drives datapath mux selects and write enables from the latched instruction opcode.
- Handles the memory ready handshake, bus timeout, illegal-opcode trap and retired-instruction count.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may stay high without mem_ready before bus-timeout trap (>=1).
- CNT_W, 32: width of the instret counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enables leaving IDLE.
- ir_opcode  in  7  inst[6:0] from the instruction register.
- branch_taken  in  1  branch comparator result, valid in EXEC.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  store when high.
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load instruction register.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1.
- alu_a_sel  out  1  0 = rs1, 1 = PC.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- alu_op  out  2  0 = add, 1 = funct-decoded, 2 = compare.
- rf_we  out  1  register-file write.
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC+4, 3 = imm.
- trap  out  1  core halted.
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = bus timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, trap=0, trap_cause=0, instret=0. All strobes and selects are 0. Reset mid-access drops mem_req immediately.
- Outputs are combinational from state, latched opcode and mem_ready. Only state, wait counter, trap_cause and instret are registered.
- Opcodes:
  - R 0110011, OPIMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode is illegal.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - mem_ready=1 in the same cycle: ir_we=1, go to DECODE, wait counter cleared.
  - mem_ready=0: wait counter increments. Reaching MEM_TIMEOUT goes to TRAP with cause 2.
- DECODE: one cycle, no strobes. Illegal opcode goes to TRAP with cause 1, otherwise to EXEC.
- EXEC selects:
  - R: a=0, b=0, op=1.
  - OPIMM: a=0, b=1, op=1.
  - LOAD/STORE: a=0, b=1, op=0.
  - AUIPC: a=1, b=1, op=0.
  - JALR: a=0, b=1, op=0.
  - BRANCH: a=0, b=0, op=2.
- EXEC transitions:
  - BRANCH: pc_we=1, pc_src = branch_taken ? 1 : 0, instret+1, go to FETCH.
  - LOAD/STORE: go to MEM.
  - Others: go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE. EXEC ALU selects are held.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE asserts pc_we=1, pc_src=0, instret+1, and goes to FETCH.
  - Timeout behaves as in FETCH (cause 2).
- WB (one cycle): rf_we=1, pc_we=1, instret+1, go to FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_src: JAL=1, JALR=2, else 0.
  - JALR holds EXEC ALU selects.
- TRAP: trap=1, all strobes 0, trap_cause held. Only rst_n exits. run is ignored.
- run=0 is sampled only in IDLE; an in-flight instruction always completes. After a retire with run=0 the FSM returns to IDLE instead of FETCH.
- Latency with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3. Each memory wait cycle adds 1.
- instret wraps modulo 2^CNT_W. Exactly one increment per retire.
- Timeout boundary: MEM_TIMEOUT consecutive wait cycles trigger the trap. Ready arriving on cycle MEM_TIMEOUT itself (counter = MEM_TIMEOUT-1) still completes.

Test Plan:
- Zero-wait ADD (0110011) after run pulse -> FETCH, DECODE, EXEC, WB over 4 cycles; rf_we=1 and wb_sel=0 in WB; instret 0 -> 1.
- LOAD with mem_ready delayed 3 cycles in MEM -> 8 cycles FETCH to retire; wb_sel=1; mem_addr_sel=1 throughout MEM.
- BRANCH with branch_taken=1, then BRANCH with branch_taken=0 -> pc_we in EXEC with pc_src 1 then 0; each retires in 3 cycles; rf_we never set.
- Opcode 0000000 -> TRAP after DECODE; trap=1, trap_cause=1; instret unchanged; FSM stays in TRAP for 20 cycles with run=1.
- MEM_TIMEOUT=4 and mem_ready stuck low in FETCH -> trap_cause=2 after 4 wait cycles. Ready on the 4th cycle in a repeat run -> normal completion.
- rst_n asserted mid-MEM STORE -> mem_req and mem_we drop the same cycle; state IDLE, instret 0; a normal fetch follows after release.
